// File: rtl/serial_divider_pkg.sv
// Shared register map, bit indices and FSM encoding for the serial divider.
// cfg_ok() is the single place where legal XLEN/UNROLL combinations are defined.
package serial_divider_pkg;

    localparam logic [2:0] ADR_DIVIDEND  = 3'd0;
    localparam logic [2:0] ADR_DIVISOR   = 3'd1;
    localparam logic [2:0] ADR_CTRL      = 3'd2;
    localparam logic [2:0] ADR_STATUS    = 3'd3;
    localparam logic [2:0] ADR_QUOTIENT  = 3'd4;
    localparam logic [2:0] ADR_REMAINDER = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_IEN    = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_DZ   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX
    } state_e;

    function automatic bit cfg_ok(int xlen, int unroll);
        return (unroll == 1 || unroll == 2 || unroll == 4) && (xlen % unroll == 0);
    endfunction

endpackage

// File: rtl/serial_divider_core.sv
// Restoring divider datapath: operand latch, sign handling, UNROLL-step
// subtract chain per cycle, and the IDLE/PREP/CALC/FIX sequencer.
module serial_divider_core
    import serial_divider_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            prep_o,
    output logic            fix_o,
    output logic            dz_pend_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int ITERS = XLEN / UNROLL;
    localparam int CW    = $clog2(ITERS + 1);

    if (!cfg_ok(XLEN, UNROLL)) begin : g_bad_cfg
        $error("serial_divider_core: XLEN must be a multiple of UNROLL, UNROLL in {1,2,4}");
    end

    state_e          state, state_nx;
    logic [XLEN-1:0] a_q, b_q, div_q, quo_q, rem_q;
    logic            sgn_q, qneg_q, rneg_q, dz_q;
    logic [CW-1:0]   cnt_q;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;

    assign a_neg = sgn_q & a_q[XLEN-1];
    assign b_neg = sgn_q & b_q[XLEN-1];
    assign a_abs = a_neg ? -a_q : a_q;
    assign b_abs = b_neg ? -b_q : b_q;

    // Each step shifts one dividend bit into the partial remainder and keeps
    // the difference only when it did not borrow.
    logic [UNROLL:0][XLEN-1:0] r_ch, q_ch;
    assign r_ch[0] = rem_q;
    assign q_ch[0] = quo_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        logic [XLEN:0] t, d;
        assign t         = {r_ch[i], q_ch[i][XLEN-1]};
        assign d         = t - {1'b0, div_q};
        assign r_ch[i+1] = d[XLEN] ? t[XLEN-1:0] : d[XLEN-1:0];
        assign q_ch[i+1] = {q_ch[i][XLEN-2:0], ~d[XLEN]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start_i) state_nx = ST_PREP;
            ST_PREP: state_nx = (b_q == '0) ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt_q == CW'(1)) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            div_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            cnt_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (start_i) begin
                    a_q   <= dividend_i;
                    b_q   <= divisor_i;
                    sgn_q <= signed_i;
                end
                ST_PREP: begin
                    div_q  <= b_abs;
                    quo_q  <= a_abs;
                    rem_q  <= '0;
                    qneg_q <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    dz_q   <= (b_q == '0);
                    cnt_q  <= CW'(ITERS);
                end
                ST_CALC: begin
                    rem_q <= r_ch[UNROLL];
                    quo_q <= q_ch[UNROLL];
                    cnt_q <= cnt_q - CW'(1);
                end
                ST_FIX: begin
                    // Divide by zero bypasses sign correction entirely.
                    if (dz_q) begin
                        quotient_o  <= '1;
                        remainder_o <= a_q;
                    end else begin
                        quotient_o  <= qneg_q ? -quo_q : quo_q;
                        remainder_o <= rneg_q ? -rem_q : rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (state != ST_IDLE);
    assign prep_o    = (state == ST_PREP);
    assign fix_o     = (state == ST_FIX);
    assign dz_pend_o = dz_q;

endmodule

// File: rtl/serial_divider_wb.sv
// Wishbone register file and interrupt around serial_divider_core.
// Writes commit in the ack cycle, so a start launches PREP the cycle after ack.
module serial_divider_wb
    import serial_divider_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1,
    parameter int WBW    = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [WBW/8-1:0] wbs_sel_i,
    input  logic [WBW-1:0]   wbs_adr_i,
    input  logic [WBW-1:0]   wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [WBW-1:0]   wbs_dat_o,
    output logic             busy_o,
    output logic             start_o,
    output logic             fini_o,
    output logic             irq_o
);

    if (WBW < XLEN) begin : g_bad_wbw
        $error("serial_divider_wb: WBW must be >= XLEN");
    end

    logic [XLEN-1:0] dividend_q, divisor_q, be_mask, quotient, remainder;
    logic            signed_q, ien_q, done_q, dz_q, fini_q, ack_q;
    logic [WBW-1:0]  dat_q, rdata;
    logic            core_busy, core_prep, core_fix, core_dz;
    logic [2:0]      idx;
    logic            req, wr, ctrl_hit, stat_hit, start_acc;
    logic            unused_bits;

    assign unused_bits = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

    assign idx       = wbs_adr_i[4:2];
    assign req       = wbs_stb_i & wbs_cyc_i;
    assign wr        = req & wbs_we_i & ack_q;
    assign ctrl_hit  = (idx == ADR_CTRL) & wbs_sel_i[0];
    assign stat_hit  = (idx == ADR_STATUS) & wbs_sel_i[0];
    assign start_acc = wr & ctrl_hit & wbs_dat_i[CTRL_START] & ~core_busy;

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < XLEN; i++) be_mask[i] = wbs_sel_i[i/8];
    end

    always_comb begin
        rdata = '0;
        case (idx)
            ADR_DIVIDEND:  rdata[XLEN-1:0] = dividend_q;
            ADR_DIVISOR:   rdata[XLEN-1:0] = divisor_q;
            ADR_CTRL: if (wbs_sel_i[0]) begin
                rdata[CTRL_SIGNED] = signed_q;
                rdata[CTRL_IEN]    = ien_q;
            end
            ADR_STATUS: if (wbs_sel_i[0]) begin
                rdata[STAT_BUSY] = core_busy;
                rdata[STAT_DONE] = done_q;
                rdata[STAT_DZ]   = dz_q;
            end
            ADR_QUOTIENT:  rdata[XLEN-1:0] = quotient;
            ADR_REMAINDER: rdata[XLEN-1:0] = remainder;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            ien_q      <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            fini_q     <= 1'b0;
        end else begin
            ack_q  <= req & ~ack_q;
            dat_q  <= (req & ~ack_q & ~wbs_we_i) ? rdata : '0;
            fini_q <= core_fix;
            if (wr && idx == ADR_DIVIDEND)
                dividend_q <= (dividend_q & ~be_mask) | (wbs_dat_i[XLEN-1:0] & be_mask);
            if (wr && idx == ADR_DIVISOR)
                divisor_q <= (divisor_q & ~be_mask) | (wbs_dat_i[XLEN-1:0] & be_mask);
            if (wr & ctrl_hit) begin
                signed_q <= wbs_dat_i[CTRL_SIGNED];
                ien_q    <= wbs_dat_i[CTRL_IEN];
            end
            // A completion in the same cycle as a clear write keeps the flag set.
            if (core_fix)
                done_q <= 1'b1;
            else if (start_acc || (wr & stat_hit & wbs_dat_i[STAT_DONE]))
                done_q <= 1'b0;
            if (core_fix & core_dz)
                dz_q <= 1'b1;
            else if (start_acc || (wr & stat_hit & wbs_dat_i[STAT_DZ]))
                dz_q <= 1'b0;
        end
    end

    serial_divider_core #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_core (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .start_i     (start_acc),
        .signed_i    (wbs_dat_i[CTRL_SIGNED]),
        .dividend_i  (dividend_q),
        .divisor_i   (divisor_q),
        .busy_o      (core_busy),
        .prep_o      (core_prep),
        .fix_o       (core_fix),
        .dz_pend_o   (core_dz),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign busy_o    = core_busy;
    assign start_o   = core_prep;
    assign fini_o    = fini_q;
    assign irq_o     = done_q & ien_q;

endmodule

// File: tb/tb_serial_divider_wb.sv
// Scoreboarded bench: two dividers (UNROLL=1 and UNROLL=4) on a shared bus,
// directed divisions with hand-computed results and timing checks.
module tb_serial_divider_wb;

    localparam logic [31:0] A_DVD = 32'h00, A_DVS = 32'h04, A_CTRL = 32'h08;
    localparam logic [31:0] A_STAT = 32'h0C, A_QUO = 32'h10, A_REM = 32'h14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc, we;
    logic [1:0]  stb;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic [1:0]  ack, busy, start, fini, irq;
    logic [1:0][31:0] dat;

    always #5 clk = ~clk;

    serial_divider_wb #(.XLEN(32), .UNROLL(1), .WBW(32)) u_div1 (
        .clk_i(clk), .reset_ni(rst_n), .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack[0]), .wbs_dat_o(dat[0]), .busy_o(busy[0]),
        .start_o(start[0]), .fini_o(fini[0]), .irq_o(irq[0]));

    serial_divider_wb #(.XLEN(32), .UNROLL(4), .WBW(32)) u_div4 (
        .clk_i(clk), .reset_ni(rst_n), .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack[1]), .wbs_dat_o(dat[1]), .busy_o(busy[1]),
        .start_o(start[1]), .fini_o(fini[1]), .irq_o(irq[1]));

    int errs = 0;
    int checks = 0;

    typedef struct {
        int          d;
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    int   blen[2], last_len[2], fini_cnt[2];
    logic [1:0] pbusy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read-response monitor plus busy/fini/start timing tracker.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                blen[d]  = 0;
                pbusy[d] = 1'b0;
            end else begin
                if (ack[d] && !we) begin
                    if (sbq.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL unexpected_read dut%0d: got %h expected none", d, dat[d]);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk({e.name, "_dut"}, d, e.d);
                        chk(e.name, dat[d], e.val);
                    end
                end
                if (!ack[d] && dat[d] != 32'h0) chk("dat_idle_zero", dat[d], 32'h0);
                if (busy[d]) blen[d]++;
                else if (pbusy[d]) begin
                    last_len[d] = blen[d];
                    blen[d] = 0;
                end
                if (fini[d]) begin
                    fini_cnt[d]++;
                    chk("fini_on_busy_fall", {30'b0, busy[d], pbusy[d]}, 32'h1);
                end
                if (start[d] || (busy[d] && !pbusy[d]))
                    chk("start_in_prep", {31'b0, start[d]}, {31'b0, busy[d] && !pbusy[d]});
                pbusy[d] = busy[d];
            end
        end
    end

    task automatic xfer(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] v, input logic [3:0] s);
        int k;
        cyc = 1'b1; stb[d] = 1'b1; we = w; adr = a; wdat = v; sel = s;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack[d] && k < 8);
        if (!ack[d]) begin
            checks++; errs++;
            $display("FAIL ack_timeout dut%0d: got no ack expected ack for adr %h", d, a);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = '0; we = 1'b0;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
        xfer(d, 1'b1, a, v, 4'hF);
    endtask

    task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp, input string name);
        sbq.push_back('{d, name, exp});
        xfer(d, 1'b0, a, 32'h0, 4'hF);
    endtask

    task automatic wait_idle(input int d);
        int k;
        k = 0;
        @(negedge clk);
        while (busy[d] && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy[d]) begin
            checks++; errs++;
            $display("FAIL busy_timeout dut%0d: got busy expected idle", d);
        end
        @(posedge clk); #1;
    endtask

    task automatic divide(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ctrl);
        wr(d, A_DVD, a);
        wr(d, A_DVS, b);
        wr(d, A_CTRL, ctrl);
        wait_idle(d);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int f0;
        cyc = 1'b0; stb = '0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
        #12;
        chk("reset_outputs", {ack, busy, start, fini, irq, dat[0][21:0]}, 32'h0);
        chk("reset_dat1", dat[1], 32'h0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        rd(0, A_STAT, 32'h0, "status_after_reset");
        rd(0, A_QUO, 32'h0, "quotient_after_reset");

        // byte enables, unmapped offsets, CTRL without sel[0]
        wr(0, A_DVD, 32'hAABBCCDD);
        xfer(0, 1'b1, A_DVD, 32'h11223344, 4'b0101);
        rd(0, A_DVD, 32'hAA22CC44, "dividend_byte_en");
        wr(0, 32'h18, 32'hDEADBEEF);
        rd(0, 32'h18, 32'h0, "unmapped_read");
        xfer(0, 1'b1, A_CTRL, 32'h5, 4'b1110);
        chk("ctrl_no_sel0_busy", {31'b0, busy[0]}, 32'h0);
        rd(0, A_CTRL, 32'h0, "ctrl_no_sel0");

        // unsigned 100/7 with irq enabled
        f0 = fini_cnt[0];
        divide(0, 32'd100, 32'd7, 32'h5);
        chk("busy_len_100_7", last_len[0], 34);
        chk("fini_once_100_7", fini_cnt[0] - f0, 1);
        chk("irq_set", {31'b0, irq[0]}, 32'h1);
        rd(0, A_QUO, 32'd14, "q_100_7");
        rd(0, A_REM, 32'd2, "r_100_7");
        rd(0, A_STAT, 32'h2, "status_done");
        rd(0, A_CTRL, 32'h4, "ctrl_readback");
        wr(0, A_CTRL, 32'h0);
        chk("irq_ien_off", {31'b0, irq[0]}, 32'h0);
        wr(0, A_CTRL, 32'h4);
        chk("irq_ien_on", {31'b0, irq[0]}, 32'h1);
        wr(0, A_STAT, 32'h2);
        chk("irq_done_clr", {31'b0, irq[0]}, 32'h0);
        rd(0, A_STAT, 32'h0, "status_cleared");

        // signed and unsigned -7 / 2
        divide(0, 32'hFFFFFFF9, 32'd2, 32'h3);
        rd(0, A_QUO, 32'hFFFFFFFD, "q_s_m7_2");
        rd(0, A_REM, 32'hFFFFFFFF, "r_s_m7_2");
        divide(0, 32'hFFFFFFF9, 32'd2, 32'h1);
        rd(0, A_QUO, 32'h7FFFFFFC, "q_u_m7_2");
        rd(0, A_REM, 32'h1, "r_u_m7_2");

        // divide by zero
        divide(0, 32'd123, 32'd0, 32'h1);
        chk("busy_len_dz", last_len[0], 2);
        rd(0, A_QUO, 32'hFFFFFFFF, "q_dz");
        rd(0, A_REM, 32'd123, "r_dz");
        rd(0, A_STAT, 32'h6, "status_dz");
        wr(0, A_STAT, 32'h4);
        rd(0, A_STAT, 32'h2, "status_dz_cleared");

        // signed overflow
        divide(0, 32'h80000000, 32'hFFFFFFFF, 32'h3);
        rd(0, A_QUO, 32'h80000000, "q_ovf");
        rd(0, A_REM, 32'h0, "r_ovf");
        rd(0, A_STAT, 32'h2, "status_ovf");

        // restart while busy is ignored
        wr(0, A_DVD, 32'd100);
        wr(0, A_DVS, 32'd7);
        f0 = fini_cnt[0];
        wr(0, A_CTRL, 32'h1);
        @(posedge clk); #1;
        wr(0, A_DVD, 32'd50);
        wr(0, A_DVS, 32'd5);
        wr(0, A_CTRL, 32'h1);
        wait_idle(0);
        repeat (4) @(posedge clk);
        #1;
        chk("no_restart", {31'b0, busy[0]}, 32'h0);
        chk("busy_len_restart", last_len[0], 34);
        chk("fini_once_restart", fini_cnt[0] - f0, 1);
        rd(0, A_QUO, 32'd14, "q_restart_ignored");
        rd(0, A_REM, 32'd2, "r_restart_ignored");
        rd(0, A_DVD, 32'd50, "dividend_updated_busy");

        // reset in the middle of CALC
        wr(0, A_DVD, 32'd100);
        wr(0, A_DVS, 32'd7);
        wr(0, A_CTRL, 32'h5);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {ack, busy, start, fini, irq, dat[0][21:0]}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        rd(0, A_STAT, 32'h0, "status_after_midreset");
        rd(0, A_QUO, 32'h0, "q_after_midreset");
        rd(0, A_DVD, 32'h0, "dividend_after_midreset");
        divide(0, 32'd100, 32'd7, 32'h1);
        rd(0, A_QUO, 32'd14, "q_after_reset_run");
        rd(0, A_REM, 32'd2, "r_after_reset_run");

        // UNROLL = 4 instance
        divide(1, 32'd100, 32'd7, 32'h1);
        chk("busy_len_u4", last_len[1], 10);
        rd(1, A_QUO, 32'd14, "q_u4_100_7");
        rd(1, A_REM, 32'd2, "r_u4_100_7");
        divide(1, 32'hFFFFFFF9, 32'd2, 32'h3);
        rd(1, A_QUO, 32'hFFFFFFFD, "q_u4_s_m7_2");
        rd(1, A_REM, 32'hFFFFFFFF, "r_u4_s_m7_2");
        divide(1, 32'd123, 32'd0, 32'h1);
        chk("busy_len_u4_dz", last_len[1], 2);
        rd(1, A_QUO, 32'hFFFFFFFF, "q_u4_dz");
        rd(1, A_STAT, 32'h6, "status_u4_dz");

        repeat (3) @(posedge clk);
        if (sbq.size() != 0) chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
